// File: rtl/sched_pkg.sv
// Shared types and default sizing for the per-level child round-robin scheduler.
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_e;

    localparam int NUM_REQ_DEF  = 5;
    localparam int MAX_HOLD_DEF = 16;

endpackage : sched_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] ereq_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Walk candidates ptr, ptr+1, ... and latch the first requesting one.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        cand_s   = '0;
        hit_s    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s   = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            hit_s    = ereq_i[cand_s] & ~valid_o;
            winner_o = hit_s ? cand_s : winner_o;
            valid_o  = valid_o | hit_s;
        end
    end

endmodule : rr_pick

// File: rtl/child_rr_scheduler.sv
// Round-robin owner of one shared resource among sibling children, with a
// maximum hold time that only pre-empts the holder when someone else waits.
module child_rr_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int IDX_W    = $clog2(NUM_REQ),
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] en_mask_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_valid_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               preempt_o,
    output logic               busy_o
);

    sched_state_e       state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               preempt_q, preempt_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] ereq_s;
    logic [IDX_W-1:0]   winner_s;
    logic               winner_valid_s;

    assign ereq_s = req_i & en_mask_i;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .ereq_i   (ereq_s),
        .ptr_i    (ptr_q),
        .winner_o (winner_s),
        .valid_o  (winner_valid_s)
    );

    // Next-state, grant, pointer and hold-counter logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        preempt_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (winner_valid_s) begin
                    state_d    = GRANT;
                    gnt_d      = NUM_REQ'(1) << winner_s;
                    gnt_idx_d  = winner_s;
                    hold_cnt_d = HOLD_W'(1);
                    ptr_d      = (winner_s == IDX_W'(NUM_REQ - 1)) ? IDX_W'(0)
                                                                    : winner_s + IDX_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // gnt_q is onehot(holder), so it doubles as the holder mask.
                if ((ereq_s & gnt_q) == NUM_REQ'(0)) begin
                    state_d = GAP;
                    gnt_d   = NUM_REQ'(0);
                end else if ((hold_cnt_q == HOLD_W'(MAX_HOLD)) &&
                             ((ereq_s & ~gnt_q) != NUM_REQ'(0))) begin
                    state_d   = GAP;
                    gnt_d     = NUM_REQ'(0);
                    preempt_d = 1'b1;
                end else if (hold_cnt_q != HOLD_W'(MAX_HOLD)) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = NUM_REQ'(0);
            end
        endcase
        gnt_valid_d = |gnt_d;
        busy_d      = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            preempt_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            preempt_q   <= preempt_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = gnt_valid_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign preempt_o   = preempt_q;
    assign busy_o      = busy_q;

endmodule : child_rr_scheduler
